// File: rtl/mem_access_unit_if.sv
// Bus bundle for mem_access_unit: CPU request/response handshake plus the
// byte-serial data-memory command port.
//
// Handshake: a request transfers on a rising edge where req_valid=1 and
// req_ready=1; the requester holds all req_* fields stable while req_valid=1.
// resp_valid is a single-cycle pulse with no back-pressure, and resp_err and
// resp_rdata are meaningful only while it is high.
//
// The memory port has no handshake. mem_en=1 with mem_we=1 writes mem_wdata
// to mem_addr on that edge. mem_en=1 with mem_we=0 returns the addressed byte
// on mem_rdata during the following cycle.
//
// The master modport is the environment: the CPU together with the data
// memory. The slave modport is the unit itself.
interface mem_access_unit_if #(
   parameter int ADDR_W = 10
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;
   // Current FSM state, exported for observation: 0 IDLE, 1 ACCESS, 2 DRAIN, 3 RESP
   logic [1:0]        dbg_state;

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      output mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_en, mem_we, mem_addr, mem_wdata, dbg_state
   );

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      input  mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_en, mem_we, mem_addr, mem_wdata, dbg_state
   );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: converts one word, half or byte load/store into N
// byte-serial memory cycles. Bytes are issued in big-endian order, so the
// most significant byte goes to the lowest address. Load bytes are assembled
// MSB-first and then zero- or sign-extended. Misaligned or illegal-size
// requests skip memory entirely and answer with an error response.
module mem_access_unit #(
   parameter int ADDR_W = 10
) (
   input logic                clk,
   input logic                rst_n,
   mem_access_unit_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DRAIN  = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t      state;
   logic        wr_q;     // latched store/load flag
   logic        uns_q;    // latched zero-extend flag
   logic [2:0]  n_q;      // byte count N of the current access
   logic [2:0]  k_q;      // index of the current ACCESS cycle
   logic [31:0] wsh_q;    // store bytes still to send, next one in [31:24]
   logic [23:0] asm_q;    // load bytes received so far, newest in [7:0]

   // Decode of the request currently on the bus
   logic        acc_err;
   logic [2:0]  acc_n;
   logic [31:0] acc_wsh;  // store data moved so its first byte sits in [31:24]
   logic        unused_addr;

   assign bus.dbg_state = state;
   // Address bits above ADDR_W are deliberately ignored
   assign unused_addr   = ^bus.req_addr;

   // Extend the 8N assembled load bits to 32 bits
   function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                               input logic [2:0]  n,
                                               input logic        uns);
      logic [31:0] r;
      r = raw;
      case (n)
         3'd1:    r = uns ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
         3'd2:    r = uns ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
         default: r = raw;
      endcase
      return r;
   endfunction

   // Classify the incoming request: byte count, alignment error, store layout
   always_comb begin
      acc_err = 1'b0;
      acc_n   = 3'd4;
      acc_wsh = bus.req_wdata;
      case (bus.req_size)
         2'b00: begin
            acc_n   = 3'd4;
            acc_wsh = bus.req_wdata;
            acc_err = (bus.req_addr[1:0] != 2'b00);
         end
         2'b01: begin
            acc_n   = 3'd2;
            acc_wsh = {bus.req_wdata[15:0], 16'h0};
            acc_err = bus.req_addr[0];
         end
         2'b10: begin
            acc_n   = 3'd1;
            acc_wsh = {bus.req_wdata[7:0], 24'h0};
            acc_err = 1'b0;
         end
         default: begin
            acc_n   = 3'd4;
            acc_wsh = bus.req_wdata;
            acc_err = 1'b1;
         end
      endcase
   end

   // Control FSM. Every output is registered and set on the edge that enters
   // the state in which it must be seen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         wr_q           <= 1'b0;
         uns_q          <= 1'b0;
         n_q            <= 3'd0;
         k_q            <= 3'd0;
         wsh_q          <= 32'h0;
         asm_q          <= 24'h0;
         bus.req_ready  <= 1'b1;
         bus.resp_valid <= 1'b0;
         bus.resp_err   <= 1'b0;
         bus.resp_rdata <= 32'h0;
         bus.mem_en     <= 1'b0;
         bus.mem_we     <= 1'b0;
         bus.mem_addr   <= '0;
         bus.mem_wdata  <= 8'h0;
      end else begin
         case (state)
            IDLE: begin
               // req_ready is high throughout IDLE, so req_valid alone accepts
               if (bus.req_valid) begin
                  bus.req_ready <= 1'b0;
                  wr_q          <= bus.req_write;
                  uns_q         <= bus.req_unsigned;
                  n_q           <= acc_n;
                  if (acc_err) begin
                     state          <= RESP;
                     bus.resp_valid <= 1'b1;
                     bus.resp_err   <= 1'b1;
                     bus.resp_rdata <= 32'h0;
                  end else begin
                     state         <= ACCESS;
                     k_q           <= 3'd0;
                     asm_q         <= 24'h0;
                     bus.mem_en    <= 1'b1;
                     bus.mem_we    <= bus.req_write;
                     bus.mem_addr  <= bus.req_addr[ADDR_W-1:0];
                     bus.mem_wdata <= acc_wsh[31:24];
                     wsh_q         <= {acc_wsh[23:0], 8'h0};
                  end
               end
            end

            ACCESS: begin
               // Read data lags its command by one cycle, so capture starts at k=1
               if (!wr_q && (k_q != 3'd0)) begin
                  asm_q <= {asm_q[15:0], bus.mem_rdata};
               end
               if (k_q == (n_q - 3'd1)) begin
                  bus.mem_en <= 1'b0;
                  bus.mem_we <= 1'b0;
                  if (wr_q) begin
                     state          <= RESP;
                     bus.resp_valid <= 1'b1;
                     bus.resp_err   <= 1'b0;
                     bus.resp_rdata <= 32'h0;
                  end else begin
                     state <= DRAIN;
                  end
               end else begin
                  k_q           <= k_q + 3'd1;
                  bus.mem_addr  <= bus.mem_addr + 1'b1;
                  bus.mem_wdata <= wsh_q[31:24];
                  wsh_q         <= {wsh_q[23:0], 8'h0};
               end
            end

            DRAIN: begin
               // The last load byte is on mem_rdata now; fold it in directly
               state          <= RESP;
               bus.resp_valid <= 1'b1;
               bus.resp_err   <= 1'b0;
               bus.resp_rdata <= extend_load({asm_q, bus.mem_rdata}, n_q, uns_q);
            end

            RESP: begin
               // resp_rdata holds its value until the next response
               state          <= IDLE;
               bus.resp_valid <= 1'b0;
               bus.resp_err   <= 1'b0;
               bus.req_ready  <= 1'b1;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit. It drives directed and random loads and
// stores, models the byte memory, and predicts every response from a plain
// byte-array reference model.
module tb_mem_access_unit;

   localparam int ADDR_W = 10;
   localparam int MSIZE  = 1 << ADDR_W;

   logic clk;
   logic rst_n;

   mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

   mem_access_unit #(.ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int fails  = 0;

   // Byte memory driven by the DUT command port
   bit [7:0] mem     [MSIZE];
   // Expected memory contents, derived only from the requests issued
   bit [7:0] ref_mem [MSIZE];

   int en_cnt   = 0;
   int acc_cnt  = 0;
   int resp_cnt = 0;

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous byte memory: write on the edge, read data available next cycle
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata     <= mem[bus.mem_addr];
      end
   end

   // Event counters: memory cycles, accepted requests, responses
   always @(posedge clk) begin
      if (bus.mem_en) en_cnt <= en_cnt + 1;
      if (rst_n && bus.req_valid && bus.req_ready) acc_cnt <= acc_cnt + 1;
      if (bus.resp_valid) resp_cnt <= resp_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request and check its response against the reference model
   task automatic do_req(input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd, input bit hold);
      int n, exp_lat, lat, en0, acc0, busy_bad;
      bit err, got;
      logic [31:0] raw, exp_rd, last_rd;
      // Reference model
      err = (sz == 2'b11) || (sz == 2'b00 && addr[1:0] != 2'b00) || (sz == 2'b01 && addr[0]);
      n   = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
      exp_lat = err ? 1 : (wr ? n + 1 : n + 2);
      exp_rd  = 32'h0;
      if (!err && !wr) begin
         raw = 32'h0;
         for (int i = 0; i < n; i++) raw = (raw << 8) | 32'(ref_mem[(addr + 32'(i)) % MSIZE]);
         if (!uns && n < 4 && raw[8*n-1]) exp_rd = raw | (32'hFFFF_FFFF << (8*n));
         else exp_rd = raw;
      end
      if (!err && wr) begin
         for (int i = 0; i < n; i++) ref_mem[(addr + 32'(i)) % MSIZE] = 8'(wd >> (8*(n-1-i)));
      end
      // Drive
      @(negedge clk);
      check("ready_idle", 32'(bus.req_ready), 32'd1);
      bus.req_valid    = 1'b1;
      bus.req_write    = wr;
      bus.req_size     = sz;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wd;
      en0  = en_cnt;
      acc0 = acc_cnt;
      @(posedge clk);
      #1;
      if (!hold) bus.req_valid = 1'b0;
      // Scramble fields: the DUT must use its latched copies
      bus.req_write    = 1'($urandom);
      bus.req_size     = 2'($urandom);
      bus.req_unsigned = 1'($urandom);
      bus.req_addr     = $urandom;
      bus.req_wdata    = $urandom;
      lat = 0; got = 0; busy_bad = 0;
      while (!got && lat < 20) begin
         @(negedge clk);
         lat++;
         if (bus.resp_valid) got = 1;
         else if (bus.req_ready) busy_bad++;
      end
      if (!got) begin
         checks++;
         fails++;
         $error("FAIL resp_timeout: observed none expected resp_valid by %0d cycles", exp_lat);
      end
      check("latency", 32'(lat), 32'(exp_lat));
      check("resp_err", 32'(bus.resp_err), 32'(err));
      check("resp_rdata", bus.resp_rdata, exp_rd);
      check("ready_busy", 32'(bus.req_ready), 32'd0);
      check("busy_ready_seen", 32'(busy_bad), 32'd0);
      check("mem_cycles", 32'(en_cnt - en0), err ? 32'd0 : 32'(n));
      last_rd = exp_rd;
      if (hold) bus.req_valid = 1'b0;
      @(negedge clk);
      check("resp_pulse", 32'(bus.resp_valid), 32'd0);
      check("rdata_hold", bus.resp_rdata, last_rd);
      check("ready_back", 32'(bus.req_ready), 32'd1);
      check("accepts", 32'(acc_cnt - acc0), 32'd1);
      if (!err && wr) begin
         for (int i = 0; i < n; i++)
            check("mem_byte", 32'(mem[(addr + 32'(i)) % MSIZE]), 32'(ref_mem[(addr + 32'(i)) % MSIZE]));
      end
   endtask

   initial begin
      int r0;
      bit wr, uns;
      logic [1:0] sz;
      logic [31:0] addr;
      rst_n            = 1'b0;
      bus.req_valid    = 1'b0;
      bus.req_write    = 1'b0;
      bus.req_size     = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h0;
      bus.req_wdata    = 32'h0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(bus.req_ready), 32'd1);
      check("rst_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_err", 32'(bus.resp_err), 32'd0);
      check("rst_rdata", bus.resp_rdata, 32'h0);
      check("rst_en", 32'(bus.mem_en), 32'd0);
      check("rst_we", 32'(bus.mem_we), 32'd0);
      check("rst_state", 32'(bus.dbg_state), 32'd0);
      rst_n = 1'b1;

      // Word store and load-back in big-endian byte order
      do_req(1, 2'b00, 0, 32'h10, 32'h1122_3344, 0);
      check("be_0x10", 32'(mem[16'h10]), 32'h11);
      check("be_0x13", 32'(mem[16'h13]), 32'h44);
      do_req(0, 2'b00, 0, 32'h10, 32'h0, 0);

      // Byte and half-word sign and zero extension
      do_req(1, 2'b10, 0, 32'h20, 32'hDEAD_BE80, 0);
      do_req(0, 2'b10, 0, 32'h20, 32'h0, 0);
      do_req(0, 2'b10, 1, 32'h20, 32'h0, 0);
      do_req(1, 2'b01, 0, 32'h22, 32'hCAFE_8001, 0);
      do_req(0, 2'b01, 0, 32'h22, 32'h0, 0);
      do_req(0, 2'b01, 1, 32'h22, 32'h0, 0);

      // Misaligned and illegal-size requests
      do_req(0, 2'b01, 0, 32'h21, 32'h0, 0);
      do_req(0, 2'b00, 0, 32'h22, 32'h0, 0);
      do_req(0, 2'b11, 0, 32'h20, 32'h0, 0);
      do_req(1, 2'b00, 0, 32'h23, 32'h5555_AAAA, 0);

      // req_valid held high through a busy load
      do_req(0, 2'b00, 1, 32'h10, 32'h0, 1);

      // Reset during the second ACCESS cycle of a word store to 0x30
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_size  = 2'b00;
      bus.req_addr  = 32'h30;
      bus.req_wdata = 32'hA1B2_C3D4;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_store_en", 32'(bus.mem_en), 32'd1);
      r0 = resp_cnt;
      rst_n = 1'b0;
      #1;
      check("abort_ready", 32'(bus.req_ready), 32'd1);
      check("abort_en", 32'(bus.mem_en), 32'd0);
      check("abort_valid", 32'(bus.resp_valid), 32'd0);
      repeat (3) @(negedge clk);
      check("abort_no_resp", 32'(resp_cnt - r0), 32'd0);
      ref_mem[32'h30] = 8'hA1;
      for (int i = 0; i < 4; i++)
         check("abort_mem", 32'(mem[32'h30 + i]), 32'(ref_mem[32'h30 + i]));
      // Release mid-cycle; the next rising edge must accept the request
      @(posedge clk);
      #2 rst_n = 1'b1;
      do_req(0, 2'b10, 1, 32'h30, 32'h0, 0);
      do_req(0, 2'b00, 0, 32'h30, 32'h0, 0);

      // Random traffic, upper address bits included
      for (int t = 0; t < 80; t++) begin
         wr   = 1'($urandom);
         uns  = 1'($urandom);
         sz   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'b00) addr[1:0] = 2'b00;
            if (sz == 2'b01) addr[0]   = 1'b0;
         end
         do_req(wr, sz, uns, addr, $urandom, 1'($urandom_range(0, 7) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", checks, fails);
      $finish;
   end

   // Global time bound
   initial begin
      #500000;
      $display("FAIL global_timeout: observed no finish expected finish within 500000");
      $fatal(1, "timeout");
   end

endmodule
